// File: rtl/pwm_cap_pkg.sv
// Shared types and widths for the PWM duty-capture block.
package pwm_cap_pkg;

    localparam int DUTY_W = 11;
    localparam int PER_W  = 12;
    localparam int CNT_W  = 12;

    localparam logic [DUTY_W-1:0] DUTY_MAX = 11'h7FF;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        HIGH,
        LOW
    } state_t;

    // One published measurement.
    typedef struct packed {
        logic [DUTY_W-1:0] duty;
        logic [PER_W-1:0]  period;
        logic              stuck;
    } result_t;

endpackage

// File: rtl/pwm_duty_capture_if.sv
// Result bus of the PWM capture: measurement plus a one-clock valid strobe.
interface pwm_duty_capture_if;
    import pwm_cap_pkg::*;

    logic [DUTY_W-1:0] duty;
    logic [PER_W-1:0]  period;
    logic              vld;
    logic              stuck;

    modport master (output duty, period, vld, stuck);
    modport slave  (input  duty, period, vld, stuck);

endinterface

// File: rtl/pwm_edge_sync.sv
// Three-flop synchronizer for an asynchronous input with edge detect.
// Only ff2 is exposed as the level so that level and edges stay aligned.
module pwm_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise,
    output logic fall,
    output logic level
);

    logic ff1, ff2, ff3;

    // Shift the input through the synchronizer chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff1 <= 1'b0;
            ff2 <= 1'b0;
            ff3 <= 1'b0;
        end else begin
            ff1 <= async_in;
            ff2 <= ff1;
            ff3 <= ff2;
        end
    end

    assign rise  = ff2 & ~ff3;
    assign fall  = ~ff2 & ff3;
    assign level = ff2;

endmodule

// File: rtl/pwm_duty_capture.sv
// Measures high time and period of an asynchronous PWM input and publishes
// one result per complete period, or a stuck result after TIMEOUT clocks
// without an edge.
module pwm_duty_capture
    import pwm_cap_pkg::*;
#(
    parameter int TIMEOUT = 2048
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               PWM_sig,
    pwm_duty_capture_if.master res
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TO_SAT  = CNT_W'(TIMEOUT);

    logic rise, fall, level, edge_any, timeout;

    state_t           state, state_nx;
    logic [CNT_W-1:0] hi_cnt, hi_nx;
    logic [CNT_W-1:0] lo_cnt, lo_nx;
    logic [CNT_W-1:0] idle_cnt;

    logic    pub;
    result_t res_nx, res_q;
    logic    vld_q;

    pwm_edge_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (PWM_sig),
        .rise     (rise),
        .fall     (fall),
        .level    (level)
    );

    assign edge_any = rise | fall;
    // An edge clears idle_cnt, so it always wins over a timeout.
    assign timeout  = ~edge_any & (idle_cnt == TO_LAST);

    // Idle counter: cleared by any edge, saturates so a timeout fires once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                idle_cnt <= '0;
        else if (edge_any)         idle_cnt <= '0;
        else if (idle_cnt != TO_SAT) idle_cnt <= idle_cnt + 1'b1;
    end

    // State and phase counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            hi_cnt <= '0;
            lo_cnt <= '0;
        end else begin
            state  <= state_nx;
            hi_cnt <= hi_nx;
            lo_cnt <= lo_nx;
        end
    end

    // Next state, counter updates and the result to publish this cycle.
    always_comb begin
        state_nx = state;
        hi_nx    = hi_cnt;
        lo_nx    = lo_cnt;
        pub      = 1'b0;
        res_nx   = '0;
        if (timeout) begin
            pub          = 1'b1;
            res_nx.stuck = 1'b1;
            if (level) begin
                res_nx.duty = DUTY_MAX;
                state_nx    = IDLE;
            end else begin
                state_nx    = ARM;
            end
        end else begin
            case (state)
                // A rise here may be left over from reset; wait for a fall.
                IDLE: if (fall) state_nx = ARM;
                ARM: begin
                    if (rise) begin
                        state_nx = HIGH;
                        hi_nx    = CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state_nx = LOW;
                        lo_nx    = CNT_W'(1);
                    end else begin
                        hi_nx    = hi_cnt + 1'b1;
                    end
                end
                LOW: begin
                    if (rise) begin
                        pub           = 1'b1;
                        res_nx.duty   = hi_cnt[DUTY_W-1:0];
                        res_nx.period = hi_cnt + lo_cnt;
                        state_nx      = HIGH;
                        hi_nx         = CNT_W'(1);
                        lo_nx         = '0;
                    end else begin
                        lo_nx         = lo_cnt + 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Output registers: results hold between valid pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= pub;
            if (pub) res_q <= res_nx;
        end
    end

    assign res.duty   = res_q.duty;
    assign res.period = res_q.period;
    assign res.stuck  = res_q.stuck;
    assign res.vld    = vld_q;

endmodule
